data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 61 ++++++
 tb/tb_data_memory.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-organised, byte-addressed data memory with per-lane write masking.
//
// Ports
//   clk        : single clock; writes take effect on the rising edge
//   rst        : synchronous active-low reset; gates writes and forces data_o to 0
//   ce         : read enable; data_o shows the addressed word when high
//   we         : write enable
//   addr_i     : byte address; word index = addr_i[IdxWidth+1:2]
//   byte_slct  : write lane mask (bit3 -> [31:24] ... bit0 -> [7:0])
//   data_i     : lane-aligned write data
//   data_o     : combinational read data (full word)
//
// Stored contents survive reset; only the write path and read output are gated.
// The storage array is named mem so contents can be preloaded by backdoor.
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int MemDepth  = 1024,
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [3:0]           byte_slct,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o
);

  localparam int IdxWidth = $clog2(MemDepth);

  // Declaration initialiser gives a zeroed array at power-up in simulation.
  logic [31:0] mem [MemDepth] = '{default: 32'h0};

  logic [IdxWidth-1:0] idx;

  // Byte offset and bits above the index range do not participate in decode,
  // so the index wraps modulo MemDepth.
  assign idx = addr_i[IdxWidth+1:2];

  logic unused_addr;
  assign unused_addr = ^{addr_i[1:0], addr_i[AddrWidth-1:IdxWidth+2]};

  // Write is independent of ce; a low rst at the edge blocks every lane.
  always_ff @(posedge clk) begin
    if (rst && we) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (byte_slct[lane]) begin
          mem[idx][8*lane +: 8] <= data_i[8*lane +: 8];
        end
      end
    end
  end

  // Asynchronous read of the current array contents: a same-cycle write is
  // only visible after the edge that commits it.
  assign data_o = (rst && ce) ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int MemDepth  = 1024;
  localparam int AddrWidth = 32;

  logic                 clk;
  logic                 rst;
  logic                 ce;
  logic                 we;
  logic [AddrWidth-1:0] addr_i;
  logic [3:0]           byte_slct;
  logic [31:0]          data_i;
  logic [31:0]          data_o;

  data_memory #(
    .MemDepth (MemDepth),
    .AddrWidth(AddrWidth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .we       (we),
    .addr_i   (addr_i),
    .byte_slct(byte_slct),
    .data_i   (data_i),
    .data_o   (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  bsel;
    logic [31:0] din;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  localparam int NumVec = 20;
  vec_t vecs [NumVec];

  logic [31:0] sb [$];
  int checks;
  int errors;

  logic [31:0] model [8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  task automatic pop_check(input string name);
    logic [31:0] exp_v;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty-scoreboard expected entry", name);
    end else begin
      exp_v = sb.pop_front();
      check(name, data_o, exp_v);
    end
  endtask

  // Drive at the falling edge, sample the combinational read before the
  // rising edge, then again just after it.
  task automatic drive_cycle(input logic r, input logic c, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d,
                             input logic [31:0] e_pre, input logic [31:0] e_post,
                             input string name);
    @(negedge clk);
    rst = r; ce = c; we = w; addr_i = a; byte_slct = b; data_i = d;
    sb.push_back(e_pre);
    sb.push_back(e_post);
    #1;
    pop_check({name, " pre"});
    @(posedge clk);
    #1;
    pop_check({name, " post"});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr_i = '0; byte_slct = 4'h0; data_i = '0;

    //            rst   ce    we    addr          bsel   din           pre           post
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 4'h2, 32'h0000AA00, 32'hDEADBEEF, 32'hDEADAAEF};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 4'h0, 32'hFFFFFFFF, 32'hDEADAAEF, 32'hDEADAAEF};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADAAEF, 32'hDEADAAEF};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0013, 4'hF, 32'h12345678, 32'hDEADAAEF, 32'h12345678};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'h12345678, 32'h12345678};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0000_1010, 4'h0, 32'h0,        32'h12345678, 32'h12345678};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_F012, 4'h0, 32'h0,        32'h12345678, 32'h12345678};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h0BADF00D, 32'h0,        32'h0BADF00D};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h0000_0040, 4'h1, 32'h000000AA, 32'h0,        32'h000000AA};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h0000_0040, 4'h8, 32'hBB000000, 32'h000000AA, 32'hBB0000AA};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h0000_0041, 4'h4, 32'h00CC0000, 32'hBB0000AA, 32'hBBCC00AA};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 4'h0, 32'h0,        32'h0,        32'h0};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0,        32'h0,        32'h0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 32'h0000_1FFC, 4'h0, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};

    repeat (2) @(posedge clk);

    for (int i = 0; i < NumVec; i++) begin
      drive_cycle(vecs[i].rst, vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].bsel,
                  vecs[i].din, vecs[i].exp_pre, vecs[i].exp_post, $sformatf("vec%0d", i));
    end

    // Reset pulse between two writes: only the first lands, contents survive.
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0060, 4'hF, 32'h11112222, 32'h0, 32'h11112222, "rst_seq wr1");
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0060, 4'h3, 32'h0000FFFF, 32'h0, 32'h0, "rst_seq blocked");
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h0000_0060, 4'h0, 32'h0, 32'h11112222, 32'h11112222, "rst_seq read");

    // Backdoor preload through the mem array.
    @(negedge clk);
    we = 1'b0;
    dut.mem[7] = 32'h55AA33CC;
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h0000_001C, 4'h0, 32'h0, 32'h55AA33CC, 32'h55AA33CC, "backdoor");

    // Random traffic on a small set of untouched words against a byte-lane model.
    for (int k = 0; k < 8; k++) model[k] = 32'h0;
    for (int n = 0; n < 200; n++) begin
      logic        r, c, w;
      logic [2:0]  sel;
      logic [3:0]  b;
      logic [31:0] d, a, e_pre, e_post;
      r   = ($urandom_range(0, 7) != 0);
      c   = ($urandom_range(0, 3) != 0);
      w   = $urandom_range(0, 1) == 1;
      sel = 3'($urandom_range(0, 7));
      b   = 4'($urandom_range(0, 15));
      d   = $urandom;
      a   = ($urandom & ~32'h0000_0FFC) | ((32'd100 + 32'(sel)) << 2);
      e_pre = (r && c) ? model[sel] : 32'h0;
      if (r && w) begin
        for (int l = 0; l < 4; l++) begin
          if (b[l]) model[sel][8*l +: 8] = d[8*l +: 8];
        end
      end
      e_post = (r && c) ? model[sel] : 32'h0;
      drive_cycle(r, c, w, a, b, d, e_pre, e_post, $sformatf("rand%0d", n));
    end

    @(negedge clk);
    we = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
